// File: rtl/instr_encode_loader.sv
// RV32I field-bundle encoder that streams packed words into instruction memory.
// One bundle per cycle; each accepted legal bundle becomes a one-cycle write.
module instr_encode_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [2:0]            fmt,
    input  logic [6:0]            op,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [31:0]           imm,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_WIDTH:0] LAST_SLOT = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t                state;
    logic   [31:0]         word;
    logic                  legal;
    logic                  hs;
    logic [ADDR_WIDTH-1:0] ptr;

    assign ptr      = count[ADDR_WIDTH-1:0];
    // count's top bit is set exactly when count == DEPTH
    assign in_ready = (state == LOAD) && !count[ADDR_WIDTH];
    assign hs       = in_valid && in_ready;
    assign busy     = (state == LOAD);
    assign done     = (state == DONE);

    always_comb begin
        legal = 1'b1;
        word  = '0;
        case (fmt)
            3'b000: word = {imm[11:0], rs1, funct3, rd, op};
            3'b001: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
            3'b010: word = {imm[12], imm[10:5], rs2, rs1, funct3,
                            imm[4:1], imm[11], op};
            3'b011: word = {imm[31:12], rd, op};
            3'b100: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            3'b101: word = {funct7, rs2, rs1, funct3, rd, op};
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= LOAD;
                        count <= '0;
                        err   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        if (!legal) begin
                            err <= 1'b1;
                        end else begin
                            mem_we    <= 1'b1;
                            mem_addr  <= BASE_ADDR + 32'({ptr, 2'b00});
                            mem_wdata <= word;
                            count     <= count + ONE;
                        end
                        // in_last wins over overflow on the final slot
                        if (in_last) begin
                            state <= DONE;
                        end else if (legal && count == LAST_SLOT) begin
                            state <= DONE;
                            err   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: fixed vectors, corner sequences, random
// traffic against a cycle-level reference model.
module tb_instr_encode_loader;

    localparam int          AW    = 2;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [AW:0] count;
    logic        busy;
    logic        done;
    logic        err;

    instr_encode_loader #(
        .ADDR_WIDTH(AW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .fmt      (fmt),
        .op       (op),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .funct3   (funct3),
        .funct7   (funct7),
        .imm      (imm),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    // reference model: 0 idle, 1 loading, 2 finished
    int          m_state;
    int          m_count;
    bit          m_err;
    bit          m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [32:0] ref_enc(
        logic [2:0] f, logic [6:0] o, logic [4:0] d, logic [4:0] s1,
        logic [4:0] s2, logic [2:0] f3, logic [6:0] f7, logic [31:0] im);
        logic [31:0] w;
        logic [31:0] base;
        base = 32'(o) | (32'(f3) << 12) | (32'(s1) << 15);
        case (f)
            3'd0: w = base | (32'(d) << 7) | ((im & 32'hFFF) << 20);
            3'd1: w = base | (32'(s2) << 20) | ((im & 32'h1F) << 7)
                      | (((im >> 5) & 32'h7F) << 25);
            3'd2: w = base | (32'(s2) << 20) | (((im >> 11) & 1) << 7)
                      | (((im >> 1) & 32'hF) << 8)
                      | (((im >> 5) & 32'h3F) << 25)
                      | (((im >> 12) & 1) << 31);
            3'd3: w = 32'(o) | (32'(d) << 7) | (im & 32'hFFFF_F000);
            3'd4: w = 32'(o) | (32'(d) << 7) | (im & 32'h000F_F000)
                      | (((im >> 11) & 1) << 20)
                      | (((im >> 1) & 32'h3FF) << 21)
                      | (((im >> 20) & 1) << 31);
            3'd5: w = base | (32'(d) << 7) | (32'(s2) << 20)
                      | (32'(f7) << 25);
            default: return {1'b0, 32'h0};
        endcase
        return {1'b1, w};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_count = 0;
        m_err   = 0;
        m_we    = 0;
        m_addr  = BASE;
        m_wdata = 0;
    endtask

    task automatic compare_all(string tag);
        check({tag, ".mem_we"}, mem_we, m_we);
        check({tag, ".mem_addr"}, mem_addr, m_addr);
        check({tag, ".mem_wdata"}, mem_wdata, m_wdata);
        check({tag, ".count"}, count, m_count);
        check({tag, ".busy"}, busy, m_state == 1);
        check({tag, ".done"}, done, m_state == 2);
        check({tag, ".err"}, err, m_err);
    endtask

    // called at posedge+1; advances one clock and checks against the model
    task automatic cyc(string tag);
        bit          rdy;
        bit          hs;
        logic [32:0] e;
        rdy = (m_state == 1) && (m_count < DEPTH);
        check({tag, ".in_ready"}, in_ready, rdy);
        hs = rdy && in_valid;
        e  = ref_enc(fmt, op, rd, rs1, rs2, funct3, funct7, imm);
        @(posedge clk);
        m_we = 0;
        if (m_state != 1) begin
            if (start) begin
                m_state = 1;
                m_count = 0;
                m_err   = 0;
            end
        end else if (hs) begin
            if (!e[32]) begin
                m_err = 1;
            end else begin
                m_we    = 1;
                m_addr  = BASE + 32'(4 * m_count);
                m_wdata = e[31:0];
                m_count++;
            end
            if (in_last) m_state = 2;
            else if (e[32] && m_count == DEPTH) begin
                m_state = 2;
                m_err   = 1;
            end
        end
        #1;
        compare_all(tag);
    endtask

    task automatic put(logic [2:0] f, logic [6:0] o, logic [4:0] d,
                       logic [4:0] s1, logic [4:0] s2, logic [2:0] f3,
                       logic [6:0] f7, logic [31:0] im, logic last);
        in_valid = 1'b1;
        fmt      = f;
        op       = o;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        funct3   = f3;
        funct7   = f7;
        imm      = im;
        in_last  = last;
    endtask

    task automatic begin_session(string tag);
        in_valid = 1'b0;
        start    = 1'b1;
        cyc(tag);
        start    = 1'b0;
    endtask

    vec_t vecs[6];
    int   nwe;

    initial begin
        vecs[0] = '{3'b101, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3};
        vecs[1] = '{3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093};
        vecs[2] = '{3'b001, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020A423};
        vecs[3] = '{3'b010, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h00000463};
        vecs[4] = '{3'b100, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 32'h010000EF};
        vecs[5] = '{3'b011, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7};

        rst = 1'b1;
        start = 1'b0;
        put(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0);
        in_valid = 1'b0;
        model_reset();
        #2;
        compare_all("reset");
        check("reset.in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        cyc("idle");

        foreach (vecs[i]) begin
            begin_session("vec_start");
            put(vecs[i].fmt, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                vecs[i].f3, vecs[i].f7, vecs[i].imm, 1'b1);
            cyc("vec");
            check("vec.word", mem_wdata, vecs[i].exp);
            check("vec.addr", mem_addr, BASE);
            check("vec.we", mem_we, 1'b1);
            check("vec.done", done, 1'b1);
            in_valid = 1'b0;
            cyc("vec_after");
        end

        // addi then sw back to back
        begin_session("is_start");
        put(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        cyc("is_addi");
        check("is.w0", mem_wdata, 32'h00500093);
        check("is.a0", mem_addr, 32'h0);
        check("is.done0", done, 1'b0);
        put(3'b001, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 1'b1);
        cyc("is_sw");
        check("is.w1", mem_wdata, 32'h0020A423);
        check("is.a1", mem_addr, 32'h4);
        check("is.we1", mem_we, 1'b1);
        check("is.done1", done, 1'b1);
        check("is.count", count, 3'd2);
        in_valid = 1'b0;
        cyc("is_after");
        check("is.ready_off", in_ready, 1'b0);

        // illegal fmt mid-stream
        begin_session("ill_start");
        put(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        cyc("ill_a");
        put(3'b110, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        cyc("ill_b");
        check("ill.no_we", mem_we, 1'b0);
        check("ill.err", err, 1'b1);
        check("ill.count", count, 3'd1);
        put(3'b011, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1);
        cyc("ill_c");
        check("ill.next_addr", mem_addr, 32'h4);
        check("ill.next_word", mem_wdata, 32'h123452B7);
        check("ill.count2", count, 3'd2);
        in_valid = 1'b0;
        cyc("ill_after");

        // overflow: five bundles, no in_last
        begin_session("ovf_start");
        nwe = 0;
        for (int k = 0; k < 5; k++) begin
            put(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k + 1), 1'b0);
            cyc("ovf");
            if (mem_we) nwe++;
        end
        check("ovf.writes", nwe, 4);
        check("ovf.last_addr", mem_addr, 32'hC);
        check("ovf.in_ready", in_ready, 1'b0);
        check("ovf.done", done, 1'b1);
        check("ovf.err", err, 1'b1);
        check("ovf.count", count, 3'd4);
        in_valid = 1'b0;
        cyc("ovf_after");

        // reset right after a handshake drops the pending write
        begin_session("rst_start");
        put(3'b101, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        check("rst.hs_ready", in_ready, 1'b1);
        @(posedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        model_reset();
        #1;
        compare_all("rst");
        check("rst.in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        begin_session("rst_again");
        put(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
        cyc("rst_again_w");
        check("rst.base_addr", mem_addr, BASE);
        check("rst.we", mem_we, 1'b1);
        in_valid = 1'b0;
        cyc("rst_again_after");

        // random traffic
        for (int k = 0; k < 400; k++) begin
            start    = ($urandom_range(0, 7) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            fmt      = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1))
                                                   : 3'($urandom_range(0, 5));
            op       = 7'($urandom);
            rd       = 5'($urandom);
            rs1      = 5'($urandom);
            rs2      = 5'($urandom);
            funct3   = 3'($urandom);
            funct7   = 7'($urandom);
            imm      = $urandom;
            in_last  = ($urandom_range(0, 5) == 0);
            cyc("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
